// File: rtl/pfx_pkg.sv
// Shared defaults for the prefix-sum / prefix-difference blocks.
package pfx_pkg;

    localparam int unsigned DEF_INT_WIDTH = 32;
    localparam int unsigned DEF_V_LEN     = 8;
    localparam int unsigned DEF_VEC_WIDTH = DEF_INT_WIDTH * DEF_V_LEN;

    // Element i of a packed vector at the default geometry (element 0 in the LSBs).
    function automatic logic [DEF_INT_WIDTH-1:0] pfx_elem(
        input logic [DEF_VEC_WIDTH-1:0] v,
        input int unsigned              i
    );
        return v[i*DEF_INT_WIDTH +: DEF_INT_WIDTH];
    endfunction

endpackage

// File: rtl/pfx_diff_lane.sv
// One element of the difference decoder: modulo-2^INT_WIDTH subtract.
module pfx_diff_lane #(
    parameter int unsigned INT_WIDTH = 32
) (
    input  logic [INT_WIDTH-1:0] minuend,
    input  logic [INT_WIDTH-1:0] subtrahend,
    output logic [INT_WIDTH-1:0] diff
);

    assign diff = minuend - subtrahend;

endmodule

// File: rtl/pfx_diff.sv
// Prefix-sum decoder: two-stage valid/ready pipeline emitting adjacent
// differences, with the last element carried across vectors of a stream.
module pfx_diff
    import pfx_pkg::*;
#(
    parameter int unsigned INT_WIDTH = DEF_INT_WIDTH,
    parameter int unsigned V_LEN     = DEF_V_LEN
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       valid_in,
    output logic                       ready_out,
    input  logic                       first_in,
    input  logic [INT_WIDTH*V_LEN-1:0] ivec,
    output logic                       valid_out,
    input  logic                       ready_in,
    output logic [INT_WIDTH*V_LEN-1:0] ovec,
    output logic [31:0]                vec_count
);

    localparam int unsigned VEC_WIDTH = INT_WIDTH * V_LEN;

    logic                 s1_valid;
    logic [VEC_WIDTH-1:0] s1_vec;
    logic [INT_WIDTH-1:0] s1_carry;
    logic [INT_WIDTH-1:0] carry;
    logic [VEC_WIDTH-1:0] diff_vec;
    logic                 adv1;
    logic                 in_xfer;
    logic                 out_xfer;

    // Stage 2 can take new data when empty or draining this cycle.
    assign adv1      = !valid_out || ready_in;
    assign ready_out = !s1_valid || adv1;
    assign in_xfer   = valid_in && ready_out;
    assign out_xfer  = valid_out && ready_in;

    for (genvar i = 0; i < V_LEN; i++) begin : g_lane
        logic [INT_WIDTH-1:0] prev;
        if (i == 0) begin : g_first
            assign prev = s1_carry;
        end else begin : g_rest
            assign prev = s1_vec[(i-1)*INT_WIDTH +: INT_WIDTH];
        end
        pfx_diff_lane #(.INT_WIDTH(INT_WIDTH)) u_lane (
            .minuend    (s1_vec[i*INT_WIDTH +: INT_WIDTH]),
            .subtrahend (prev),
            .diff       (diff_vec[i*INT_WIDTH +: INT_WIDTH])
        );
    end

    // Stage 1 and the stream carry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_vec   <= '0;
            s1_carry <= '0;
            carry    <= '0;
        end else if (in_xfer) begin
            s1_valid <= 1'b1;
            s1_vec   <= ivec;
            s1_carry <= first_in ? '0 : carry;
            carry    <= ivec[(V_LEN-1)*INT_WIDTH +: INT_WIDTH];
        end else if (adv1) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2 output register and delivered-vector counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_out <= 1'b0;
            ovec      <= '0;
            vec_count <= '0;
        end else begin
            if (adv1) begin
                valid_out <= s1_valid;
                if (s1_valid) begin
                    ovec <= diff_vec;
                end
            end
            if (out_xfer) begin
                vec_count <= vec_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_pfx_diff.sv
// Randomized and directed bench for pfx_diff against a stream-level reference model.
module tb_pfx_diff;
    import pfx_pkg::*;

    localparam int unsigned W  = 32;
    localparam int unsigned N  = 8;
    localparam int unsigned VW = W * N;
    typedef logic [VW-1:0] vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in;
    logic        ready_out;
    logic        first_in;
    vec_t        ivec;
    logic        valid_out;
    logic        ready_in = 1'b1;
    vec_t        ovec;
    logic [31:0] vec_count;

    pfx_diff #(.INT_WIDTH(W), .V_LEN(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .first_in  (first_in),
        .ivec      (ivec),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .ovec      (ovec),
        .vec_count (vec_count)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    vec_t        exp_q[$];
    logic [31:0] mdl_carry = '0;
    logic [31:0] exp_cnt = '0;
    bit          rand_rdy = 1'b0;
    bit          rdy_dir = 1'b1;
    bit          prev_stall = 1'b0;
    vec_t        prev_ovec = '0;

    task automatic chk(input string name, input logic [VW-1:0] got, input logic [VW-1:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // Pfxsum reference: running sum starting from base.
    function automatic vec_t pfxsum(input vec_t x, input logic [31:0] base);
        vec_t        r;
        logic [31:0] run;
        run = base;
        for (int i = 0; i < N; i++) begin
            run = run + x[i*W +: W];
            r[i*W +: W] = run;
        end
        return r;
    endfunction

    // Decoded stream: each element minus the one before it in the stream.
    function automatic vec_t diffs(input vec_t v, input logic [31:0] prev0);
        vec_t        r;
        logic [31:0] prev;
        prev = prev0;
        for (int i = 0; i < N; i++) begin
            r[i*W +: W] = v[i*W +: W] - prev;
            prev = v[i*W +: W];
        end
        return r;
    endfunction

    function automatic vec_t rand_vec();
        vec_t r;
        for (int i = 0; i < N; i++) r[i*W +: W] = $urandom;
        return r;
    endfunction

    // Ready: random while rand_rdy, else the directed level.
    always @(posedge clk) begin
        #1;
        ready_in = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_dir;
    end

    // Compare process: output transfers, hold stability, counter.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_cnt    = '0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", VW'(valid_out), VW'(1'b1));
                chk("hold_ovec", ovec, prev_ovec);
            end
            chk("vec_count", VW'(vec_count), VW'(exp_cnt));
            if (valid_out && ready_in) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL spurious_out: got ovec %h, expected no output", ovec);
                end else begin
                    chk("ovec", ovec, exp_q.pop_front());
                end
                exp_cnt = exp_cnt + 32'd1;
            end
            prev_stall = valid_out && !ready_in;
            prev_ovec  = ovec;
        end
    end

    task automatic wait_accept(input vec_t e);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            if (ready_out) ok = 1'b1;
        end
        if (ok) begin
            exp_q.push_back(e);
        end else begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: got ready_out 0 for 200 cycles, expected 1");
            valid_in = 1'b0;
        end
    endtask

    task automatic drive(input vec_t v, input logic f, input vec_t e);
        @(posedge clk);
        #1;
        valid_in = 1'b1;
        ivec     = v;
        first_in = f;
        wait_accept(e);
    endtask

    task automatic send_raw(input vec_t v, input logic f);
        vec_t e;
        e = diffs(v, f ? 32'd0 : mdl_carry);
        mdl_carry = pfx_elem(v, N-1);
        drive(v, f, e);
    endtask

    task automatic idle_input();
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        exp_q.delete();
        mdl_carry = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drain();
        for (int c = 0; c < 200 && exp_q.size() != 0; c++) @(negedge clk);
        chk("drain_empty", VW'(exp_q.size()), VW'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by 500000, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t x1, x2, v, e, lit;
        logic [31:0] lit_e0;
        rst_n    = 1'b0;
        valid_in = 1'b0;
        first_in = 1'b0;
        ivec     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid_out", VW'(valid_out), VW'(1'b0));
        chk("rst_ovec", ovec, VW'(0));
        chk("rst_vec_count", VW'(vec_count), VW'(0));
        chk("rst_ready_out", VW'(ready_out), VW'(1'b1));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic decode and chained vector.
        for (int i = 0; i < N; i++) begin
            x1[i*W +: W] = 32'(i + 1);
            x2[i*W +: W] = 32'(i + 9);
        end
        v   = pfxsum(x1, 32'd0);
        lit = {32'd36, 32'd28, 32'd21, 32'd15, 32'd10, 32'd6, 32'd3, 32'd1};
        chk("pin_pfxsum", v, lit);
        send_raw(v, 1'b1);
        v   = pfxsum(x2, 32'd36);
        lit = {32'd136, 32'd120, 32'd105, 32'd91, 32'd78, 32'd66, 32'd55, 32'd45};
        chk("pin_pfxsum_chain", v, lit);
        chk("pin_diff_chain", diffs(v, 32'd36), x2);
        send_raw(v, 1'b0);
        idle_input();
        @(negedge clk);
        chk("basic_valid", VW'(valid_out), VW'(1'b1));
        chk("basic_ovec", ovec, x1);
        @(negedge clk);
        chk("chain_valid", VW'(valid_out), VW'(1'b1));
        chk("chain_ovec", ovec, x2);
        chk("chain_count", VW'(vec_count), VW'(1));
        drain();

        // Wrap-around and new stream.
        send_raw(pfxsum(x1, 32'd0), 1'b1);
        v = '0;
        e = diffs(v, mdl_carry);
        lit_e0 = 32'hFFFF_FFDC;
        chk("pin_wrap_e0", VW'(pfx_elem(e, 0)), VW'(lit_e0));
        send_raw(v, 1'b0);
        v = rand_vec();
        v[W-1:0] = 32'd5;
        e = diffs(v, 32'd0);
        chk("pin_new_stream_e0", VW'(pfx_elem(e, 0)), VW'(32'd5));
        send_raw(v, 1'b1);
        idle_input();
        drain();

        // Backpressure: three vectors offered while the sink stalls.
        rdy_dir = 1'b0;
        repeat (2) @(posedge clk);
        send_raw(rand_vec(), 1'b0);
        send_raw(rand_vec(), 1'b0);
        v = rand_vec();
        e = diffs(v, mdl_carry);
        mdl_carry = pfx_elem(v, N-1);
        @(posedge clk);
        #1;
        ivec     = v;
        first_in = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_ready_out", VW'(ready_out), VW'(1'b0));
        end
        rdy_dir = 1'b1;
        wait_accept(e);
        idle_input();
        drain();

        // Reset with both stages full, then a carry-less continuation.
        rdy_dir = 1'b0;
        repeat (2) @(posedge clk);
        send_raw(rand_vec(), 1'b1);
        send_raw(rand_vec(), 1'b0);
        do_reset();
        rdy_dir = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", VW'(valid_out), VW'(1'b0));
        chk("mid_rst_count", VW'(vec_count), VW'(0));
        send_raw(rand_vec(), 1'b0);
        idle_input();
        drain();

        // Random round trip through the Pfxsum model.
        do_reset();
        rand_rdy = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            logic f;
            vec_t x;
            if ($urandom_range(0, 3) == 0) idle_input();
            x = rand_vec();
            f = (k == 0) || ($urandom_range(0, 15) == 0);
            v = pfxsum(x, f ? 32'd0 : mdl_carry);
            mdl_carry = pfx_elem(v, N-1);
            drive(v, f, x);
        end
        idle_input();
        rand_rdy = 1'b0;
        rdy_dir  = 1'b1;
        drain();
        @(negedge clk);
        chk("random_vec_count", VW'(vec_count), VW'(1000));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
